// File: rtl/mem_fifo_packer.sv
// Packs LANES consecutive WIDTH-bit items into one word.
// Each word leaves through a single valid/ready output register.
module mem_fifo_packer #(
   parameter  int WIDTH = 8,
   parameter  int LANES = 4,
   localparam int CW    = $clog2(LANES+1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [WIDTH-1:0]   in,
   input  logic               wr,
   input  logic               flush,
   output logic               full,
   output logic [WIDTH*LANES-1:0] out_data,
   output logic [CW-1:0]      out_count,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               overflow
);

   logic [WIDTH*LANES-1:0] acc;
   logic [WIDTH*LANES-1:0] merged;
   logic [CW-1:0]          acc_cnt;
   logic [CW-1:0]          eff_cnt;
   logic                   flush_pend;
   logic                   slot_free;
   logic                   accept;
   logic                   last;
   logic                   complete;
   logic                   flush_req;
   logic                   emit_part;
   logic                   load;

   assign last      = (acc_cnt == CW'(LANES-1));
   assign full      = out_valid && last;
   assign slot_free = !out_valid || out_ready;
   assign accept    = wr && !full;
   assign complete  = accept && last;
   assign eff_cnt   = acc_cnt + {{(CW-1){1'b0}}, accept};
   assign flush_req = flush || flush_pend;
   assign emit_part = !complete && flush_req &&
                      (eff_cnt != '0) && slot_free;
   assign load      = complete || emit_part;

   // Accumulator with the incoming item dropped into its lane.
   always_comb begin
      merged = acc;
      for (int i = 0; i < LANES; i++) begin
         if (accept && (acc_cnt == CW'(i)))
            merged[i*WIDTH +: WIDTH] = in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc        <= '0;
         acc_cnt    <= '0;
         flush_pend <= 1'b0;
         out_data   <= '0;
         out_count  <= '0;
         out_valid  <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         if (wr && full)
            overflow <= 1'b1;
         if (load) begin
            out_data   <= merged;
            out_count  <= eff_cnt;
            out_valid  <= 1'b1;
            acc        <= '0;
            acc_cnt    <= '0;
            flush_pend <= 1'b0;
         end else begin
            if (out_valid && out_ready)
               out_valid <= 1'b0;
            if (accept) begin
               acc     <= merged;
               acc_cnt <= eff_cnt;
            end
            // Slot busy: remember the flush until it drains.
            if (flush_req && (eff_cnt != '0))
               flush_pend <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mem_fifo_packer.sv
// Randomized and directed bench for mem_fifo_packer.
// Uses a queue-based reference of the packing rules.
module tb_mem_fifo_packer;

   localparam int WIDTH = 8;
   localparam int LANES = 4;
   localparam int CW    = $clog2(LANES+1);
   localparam int DW    = WIDTH*LANES;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [WIDTH-1:0] in;
   logic             wr;
   logic             flush;
   logic             full;
   logic [DW-1:0]    out_data;
   logic [CW-1:0]    out_count;
   logic             out_valid;
   logic             out_ready;
   logic             overflow;

   int errors = 0;
   int checks = 0;

   logic [WIDTH-1:0] q[$];
   logic             m_valid;
   logic [DW-1:0]    m_data;
   int               m_count;
   logic             m_pend;
   logic             m_ovf;

   always #5 clk = ~clk;

   mem_fifo_packer #(.WIDTH(WIDTH), .LANES(LANES)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in       (in),
      .wr       (wr),
      .flush    (flush),
      .full     (full),
      .out_data (out_data),
      .out_count(out_count),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .overflow (overflow)
   );

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic m_full();
      return m_valid && (q.size() == LANES-1);
   endfunction

   task automatic m_reset();
      q.delete();
      m_valid = 1'b0;
      m_data  = '0;
      m_count = 0;
      m_pend  = 1'b0;
      m_ovf   = 1'b0;
   endtask

   task automatic m_emit();
      m_data = '0;
      foreach (q[i]) m_data[i*WIDTH +: WIDTH] = q[i];
      m_count = q.size();
      m_valid = 1'b1;
      m_pend  = 1'b0;
      q.delete();
   endtask

   // One clock edge of the reference, using the inputs seen there.
   task automatic m_step();
      logic f;
      logic freed;
      f     = m_full();
      freed = !m_valid || out_ready;
      if (wr && f) m_ovf = 1'b1;
      if (wr && !f) q.push_back(in);
      if (m_valid && out_ready) m_valid = 1'b0;
      if (q.size() == LANES) m_emit();
      else if ((flush || m_pend) && q.size() > 0) begin
         if (freed) m_emit();
         else m_pend = 1'b1;
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".valid"}, 64'(out_valid), 64'(m_valid));
      check({tag, ".data"},  64'(out_data),  64'(m_data));
      check({tag, ".count"}, 64'(out_count), 64'(m_count));
      check({tag, ".full"},  64'(full),      64'(m_full()));
      check({tag, ".ovf"},   64'(overflow),  64'(m_ovf));
   endtask

   // Called at a negedge: drive, clock, then compare.
   task automatic tick(input logic w, input logic [WIDTH-1:0] d,
                       input logic fl, input logic rdy,
                       input string tag);
      wr = w; in = d; flush = fl; out_ready = rdy;
      @(posedge clk);
      m_step();
      @(negedge clk);
      check_all(tag);
   endtask

   task automatic do_reset();
      wr = 0; in = 0; flush = 0; out_ready = 0;
      rst_n = 1'b0;
      m_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_all("reset");
      check("reset.data0", 64'(out_data), 64'h0);
   endtask

   task automatic fill_word(input logic [WIDTH-1:0] b);
      for (int i = 0; i < LANES; i++)
         tick(1, b + WIDTH'(i), 0, 0, "fill");
   endtask

   initial begin
      do_reset();

      // basic pack
      tick(1, 8'h11, 0, 1, "bp");
      tick(1, 8'h22, 0, 1, "bp");
      tick(1, 8'h33, 0, 1, "bp");
      tick(1, 8'h44, 0, 1, "bp");
      check("bp.word", 64'(out_data), 64'h44332211);
      check("bp.cnt", 64'(out_count), 64'd4);
      tick(0, 0, 0, 1, "bp.drop");
      check("bp.oneshot", 64'(out_valid), 64'd0);

      // back-pressure and overflow
      for (int i = 1; i <= 8; i++)
         tick(1, WIDTH'(i), 0, 0, "bk");
      check("bk.hold", 64'(out_data), 64'h04030201);
      check("bk.full", 64'(full), 64'd1);
      check("bk.ovf", 64'(overflow), 64'd1);
      tick(0, 0, 0, 1, "bk.xfer");
      check("bk.free", 64'(full), 64'd0);
      tick(1, 8'h08, 0, 1, "bk.w2");
      check("bk.word2", 64'(out_data), 64'h08070605);
      tick(0, 0, 0, 1, "bk.idle");

      // flush partial
      tick(1, 8'hAA, 0, 1, "fp");
      tick(1, 8'hBB, 0, 1, "fp");
      tick(0, 0, 1, 1, "fp.fl");
      check("fp.word", 64'(out_data), 64'h0000BBAA);
      check("fp.cnt", 64'(out_count), 64'd2);
      tick(0, 0, 1, 1, "fp.noop");
      check("fp.noop", 64'(out_valid), 64'd0);

      // flush with write
      tick(1, 8'hCC, 0, 1, "fw");
      tick(1, 8'hDD, 1, 1, "fw.fl");
      check("fw.word", 64'(out_data), 64'h0000DDCC);
      check("fw.cnt", 64'(out_count), 64'd2);
      tick(0, 0, 0, 1, "fw.idle");

      // flush pending
      fill_word(8'h60);
      tick(1, 8'h55, 1, 0, "pd.req");
      tick(0, 0, 0, 0, "pd.wait");
      check("pd.held", 64'(out_data), 64'h63626160);
      tick(0, 0, 0, 1, "pd.emit");
      check("pd.word", 64'(out_data), 64'h55);
      check("pd.cnt", 64'(out_count), 64'd1);
      check("pd.valid", 64'(out_valid), 64'd1);
      tick(0, 0, 0, 1, "pd.idle");

      // reset while pending
      fill_word(8'h70);
      tick(1, 8'h55, 1, 0, "pr.req");
      rst_n = 1'b0;
      wr = 0; flush = 0; out_ready = 1;
      #1;
      m_reset();
      check("pr.valid", 64'(out_valid), 64'd0);
      check("pr.data", 64'(out_data), 64'd0);
      check("pr.cnt", 64'(out_count), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) tick(0, 0, 0, 1, "pr.after");

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         logic w;
         w = ($urandom_range(99) < 60);
         if (m_full() && $urandom_range(99) >= 3) w = 1'b0;
         tick(w, WIDTH'($urandom), ($urandom_range(99) < 10),
              ($urandom_range(99) < 50), "rnd");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
